// File: rtl/button_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg
// Shared types and defaults for the push-button conditioning front end.
//   btn_state_t   : debounce FSM state (2-bit encoding)
//   DEF_*         : default parameter values for a 50 MHz system clock
//   cnt_width()   : counter width helper, never returns less than 1 bit
// ----------------------------------------------------------------------------
package button_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 10000000;  // 200 ms

    // Bits needed to hold 0..n-1; equals $clog2(n) for n >= 2.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// ----------------------------------------------------------------------------
// button_conditioner_if
// Groups the button-side and counter-side signals of one conditioner.
//   button : raw asynchronous pad level, high = pressed
//   change : one-cycle pulse per accepted press / repeat
//   level  : debounced button state
// Modports: slave = conditioner (consumes button), master = driver/observer.
// ----------------------------------------------------------------------------
interface button_conditioner_if;
    logic button;
    logic change;
    logic level;

    modport master (output button, input change, input level);
    modport slave  (input button, output change, output level);
endinterface

// File: rtl/btn_sync.sv
// ----------------------------------------------------------------------------
// btn_sync
// Two-flop synchroniser for asynchronous pad inputs, reset to 0.
//   clk  : destination clock
//   rst  : synchronous active-high reset
//   i_d  : asynchronous input(s)
//   o_q  : synchronised output(s), two edges of latency
// ----------------------------------------------------------------------------
module btn_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
// Synchronises, debounces and edge-detects one mechanical push button, giving
// a registered one-cycle `change` pulse per accepted press plus the debounced
// `level`.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   bus.button : raw bouncing pad level (in)
//   bus.change : one-cycle pulse per press (and per repeat) (out)
//   bus.level  : debounced state (out)
// Optional feature macro: BUTTON_AUTO_REPEAT_EN -- when defined, `change`
// also auto-repeats while the button stays held.
// ----------------------------------------------------------------------------
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    localparam int               CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    DEB_TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic       w_btn_s;
    btn_state_t r_state;
    logic [CW-1:0] r_cnt;
    logic       r_level;
    logic       r_change;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int            RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW      = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] RD_TERM = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_TERM = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] r_rpt_cnt;
    logic          r_rpt_first_done;   // initial delay elapsed, now on period
    logic [RW-1:0] w_rpt_term;

    assign w_rpt_term = r_rpt_first_done ? RP_TERM : RD_TERM;
`else
    // Repeat parameters are inert in this build; fold them into a constant
    // so they stay referenced without generating any logic.
    logic w_unused_rpt_cfg;
    assign w_unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    btn_sync #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (bus.button),
        .o_q (w_btn_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_level  <= 1'b0;
            r_change <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            r_rpt_cnt        <= '0;
            r_rpt_first_done <= 1'b0;
`endif
        end else begin
            r_change <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_level <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
                    r_rpt_cnt        <= '0;
                    r_rpt_first_done <= 1'b0;
`endif
                    if (w_btn_s) begin
                        r_cnt   <= '0;
                        r_state <= DEB_PRESS;
                    end
                end

                DEB_PRESS: begin
                    if (!w_btn_s) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (r_cnt == DEB_TERM) begin
                        r_level  <= 1'b1;
                        r_change <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= HELD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                HELD: begin
                    r_level <= 1'b1;
                    if (!w_btn_s) begin
                        r_cnt   <= '0;
                        r_state <= DEB_RELEASE;
                    end
`ifdef BUTTON_AUTO_REPEAT_EN
                    // Repeat counter only advances while settled in HELD;
                    // a rejected release bounce leaves it paused, not cleared.
                    else if (r_rpt_cnt == w_rpt_term) begin
                        r_change         <= 1'b1;
                        r_rpt_cnt        <= '0;
                        r_rpt_first_done <= 1'b1;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + 1'b1;
                    end
`endif
                end

                DEB_RELEASE: begin
                    if (w_btn_s) begin
                        r_cnt   <= '0;
                        r_state <= HELD;
                    end else if (r_cnt == DEB_TERM) begin
                        r_level <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.change = r_change;
    assign bus.level  = r_level;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end conditioning stage for each mechanical push-button feeding the up/down digit-counter control logic. It synchronises the raw pad input, debounces it with a cycle-count filter, and emits a single-cycle `change` pulse per accepted press, which the counter FSM consumes directly. Optionally, it auto-repeats the pulse while the button is held. One instance sits between each board button and the counter control.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: input must be stable this many cycles to be accepted (10 ms at 50 MHz); legal range ≥ 2.
- `REPEAT_DELAY`, default 25000000: cycles a press must be held before the first auto-repeat pulse; only used with `AUTO_REPEAT_EN`.
- `REPEAT_PERIOD`, default 10000000: cycles between successive auto-repeat pulses; ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `button`  in  1  raw, asynchronous, bouncing button level; active-high = pressed.
- `change`  out  1  one-cycle pulse per accepted press, and per repeat when enabled.
- `level`  out  1  debounced button state.

## Operation
- **Synchroniser.** Two flops, `button` → `btn_s`. No other logic ever reads `button`.
- **FSM states.**
  - `IDLE`: `level`=0. If `btn_s`=1, clear the counter and go to `DEB_PRESS`.
  - `DEB_PRESS`: the counter increments each cycle `btn_s`=1.
    - If `btn_s`=0, return to `IDLE` with the counter cleared (bounce rejected).
    - When the counter reaches `DEBOUNCE_CYCLES-1` with `btn_s`=1: set `level`=1, pulse `change`, clear the counter, and go to `HELD`.
  - `HELD`: `level`=1.
    - If `btn_s`=0, clear the counter and go to `DEB_RELEASE`.
    - With `AUTO_REPEAT_EN`, the repeat counter runs (see Configuration).
  - `DEB_RELEASE`: the counter increments each cycle `btn_s`=0.
    - If `btn_s`=1, return to `HELD` with the counter cleared. The repeat counter resumes from the value it had, and no `change` pulse is emitted.
    - When the counter reaches `DEBOUNCE_CYCLES-1` with `btn_s`=0: set `level`=0 and go to `IDLE`. No pulse on release.
- **Widths.** Debounce counter is `$clog2(DEBOUNCE_CYCLES)` bits. Repeat counter is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD))` bits. Neither counter wraps: each is cleared on terminal count or state exit, never incremented past it.
- **`change`** is registered and high for exactly one cycle per event. Two pulses are always separated by at least one low cycle.
- **Reset mid-operation.** A reset in any state returns to `IDLE` on the next edge. Counters clear and both outputs are driven to 0. No pulse is emitted on reset exit, even if `button` is held; a held button is re-debounced from scratch.

## Timing
- **Reset values.** `level`=0, `change`=0, state=`IDLE`, synchroniser flops=0, counters=0.
- **Press latency.** `button` rises and stays stable before edge 0. `btn_s` is high after edge 1. `change` and `level` go high after edge 2+`DEBOUNCE_CYCLES`. `change` falls one edge later.
- **Release latency.** `level` falls 2+`DEBOUNCE_CYCLES` edges after a stable low input.
- **Glitch rejection.** Any glitch shorter than `DEBOUNCE_CYCLES` cycles, seen at `btn_s`, produces no output change.
- **Output behaviour.** Outputs change only on `clk` rising edges. There is no combinational path from `button` to any output.

## Configuration
- **`BUTTON_AUTO_REPEAT_EN` defined.**
  - In `HELD`, the repeat counter counts up. First pulse: `change` fires when it reaches `REPEAT_DELAY-1` after entry.
  - After that, `change` fires every `REPEAT_PERIOD` cycles while in `HELD`.
  - The repeat counter clears on `IDLE`.
- **Macro undefined.** No repeat counter is synthesised, and `REPEAT_DELAY`/`REPEAT_PERIOD` are ignored. Exactly one `change` pulse per press.

## Structure
- **Shared package `button_pkg`.**
  - `btn_state_t` enum: `IDLE`, `DEB_PRESS`, `HELD`, `DEB_RELEASE`; 2-bit encoding.
  - Default-value localparams for the three parameters at 50 MHz.
- **Sub-module `btn_sync`.** Two-flop synchroniser, reset to 0. It is instantiated once here and reusable for other pad inputs.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8.
- **Clean press.** Raise `button` before edge 0 and hold it 30 cycles → `change` high only in the cycle after edge 6, `level` high from edge 6. With the macro undefined, there are no further pulses.
- **Bounce rejection.** `button` toggles 1,0,1,1,0,1 on successive cycles, then stays high → no pulse during the bounce; a single pulse 6 edges after the last rising transition.
- **Release bounce.** While `HELD`, drop `button` for 2 cycles then restore it → `level` stays 1 and there is no `change`. A stable low for 10 cycles → `level` falls 6 edges after the drop, with no `change`.
- **Reset mid-operation.**
  - Assert `rst` for 1 cycle while in `DEB_PRESS` → outputs 0 on the next edge, no pulse on exit.
  - Assert `rst` with `button` held → `change` pulses 6 edges after `rst` deasserts.
- **Auto-repeat (`BUTTON_AUTO_REPEAT_EN`).** Hold `button` for 60 cycles → first pulse at edge 6, repeat pulses at edges 26, 34, 42, 50, 58.
- **Short-press repeat check.** Hold 15 cycles → exactly one pulse.
